cordic_nco_ctrl: RTL and testbench
==================================

Name: cordic_nco_ctrl

Overview:
Upstream phase-generation and sequencing stage for the CORDIC rotator.
- Keeps a wrapped phase accumulator in the CORDIC angle format (radians × 2^(ANGLE_WIDTH-3)).
- Issues one CORDIC job per sample and waits for the job to finish.
- Captures cosine/sine results and presents them downstream with a valid/ready handshake.
- Turns the CORDIC into a streaming NCO (numerically controlled oscillator).

Parameters:
- WIDTH, 16: coordinate width, Q2.14 (matches CORDIC).
- ANGLE_WIDTH, 32: angle width, radians × 2^(ANGLE_WIDTH-3).
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run; new jobs are issued only while high
- phase_step  in  ANGLE_WIDTH  signed per-sample increment; |step| < PI_FX required
- phase_load  in  1  load phase_init into the accumulator
- phase_init  in  ANGLE_WIDTH  signed load value; |value| <= PI_FX required
- cordic_start  out  1  one-cycle job start pulse
- cordic_angle  out  ANGLE_WIDTH  signed angle to CORDIC
- cordic_x_start  out  WIDTH  constant CORDIC_GAIN (16'h26DD)
- cordic_y_start  out  WIDTH  constant 0
- cordic_done  in  1  CORDIC done; may be a level
- cordic_cos  in  WIDTH  CORDIC cosine
- cordic_sin  in  WIDTH  CORDIC sine
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts
- out_cos  out  WIDTH  captured cosine
- out_sin  out  WIDTH  captured sine
- out_phase  out  ANGLE_WIDTH  phase of the sample
- busy  out  1  FSM not in IDLE
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (asynchronous): FSM to IDLE; accumulator to 0. Reset values of outputs:
  - 0: cordic_start, cordic_angle, out_valid, out_cos, out_sin, out_phase, busy, timeout_err, done_q.
  - Constants: cordic_x_start = CORDIC_GAIN; cordic_y_start = 0.
  - Reset mid-job abandons the job; no output is produced.
- Constants:
  - PI_FX = 1686629713
  - HALF_PI_FX = 843314857
  - TWO_PI_FX = 3373259426 (needs a 34-bit signed intermediate)
- Accumulator invariant: acc is always in [-PI_FX, PI_FX).
- Accumulator advance: s = acc + step, computed in 34 bits.
  - If s >= PI_FX: acc <= s - TWO_PI_FX.
  - Else if s < -PI_FX: acc <= s + TWO_PI_FX.
  - Else: acc <= s.
- Load: phase_load in any state sets acc <= phase_init, with phase_init = PI_FX mapped to -PI_FX. Load beats a simultaneous advance. A job already in flight keeps its latched angle.
- FSM states:
  - IDLE: if enable, latch cordic_angle <= acc and out_phase_next <= acc, then go to ISSUE.
  - ISSUE: cordic_start = 1 for exactly this cycle, then go to WAIT.
  - WAIT:
    - done_q registers cordic_done; completion is the rising edge cordic_done & ~done_q, so a stale high level is ignored.
    - On the edge: capture cos/sin into out_*, set out_phase, advance acc, out_valid <= 1, go to HOLD.
    - If TIMEOUT_CYCLES elapse without the edge: set timeout_err, go to IDLE, acc unchanged, no output.
  - HOLD:
    - out_valid and all out_* stay stable until out_ready.
    - On accept with enable high: latch the next angle and go to ISSUE (back-to-back jobs).
    - On accept with enable low: go to IDLE.
- Latency: enable sampled in IDLE → cordic_start on the 2nd edge → out_valid one cycle after the done edge.
- Dropping enable mid-job still completes and delivers the current sample.

Optional Feature:
Macro CORDIC_QUAD_FOLD_EN.
- Defined: the job angle is folded into [-HALF_PI_FX, HALF_PI_FX].
  - angle > HALF_PI_FX: send angle - PI_FX and set fold flag.
  - angle < -HALF_PI_FX: send angle + PI_FX and set fold flag.
  - With fold flag set, the captured cos/sin are negated with saturation: -(-2^(WIDTH-1)) → 2^(WIDTH-1)-1.
  - out_phase always reports the unfolded angle.
- Undefined: the angle is passed unchanged and results are captured raw.

Decomposition:
- Package cordic_pkg holds:
  - PI_FX, HALF_PI_FX, TWO_PI_FX
  - CORDIC_GAIN
  - FSM state enum (IDLE, ISSUE, WAIT, HOLD)
- One sub-module, cordic_phase_wrap: the combinational 34-bit add and wrap, reused for advance and for fold.

Test Plan:
1. Reset then enable, step=843314856 (90°) → out_phase sequence 0, 843314856, 1686629712, -843314858; out_cos ≈ 16384, 0, -16384, 0 (±164 LSB).
2. cordic_done held high from a previous job across a new start → no capture until a fresh rising edge; exactly one out_valid per cordic_start.
3. out_ready low for 10 cycles in HOLD → out_* unchanged, no new cordic_start; ready high → next cordic_start 1 cycle later.
4. CORDIC model never raises done → timeout_err = 1 after 64 WAIT cycles, FSM in IDLE, acc unchanged, out_valid = 0.
5. phase_load with phase_init = 1686629713 in the same cycle as an advance → acc = -1686629713; in-flight sample keeps its old phase.
6. With CORDIC_QUAD_FOLD_EN: acc = 1686629712 → cordic_angle = -1, out_cos ≈ -16384, out_phase = 1686629712; assert reset mid-WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared angle constants, CORDIC start gain and sequencer state codes.
// Angles are radians x 2^29 (ANGLE_WIDTH = 32), held here in 34 bits so 2*pi fits signed.
package cordic_pkg;

  localparam logic signed [33:0] PI_FX      = 34'sd1686629713;
  localparam logic signed [33:0] HALF_PI_FX = 34'sd843314857;
  localparam logic signed [33:0] TWO_PI_FX  = 34'sd3373259426;
  localparam logic signed [33:0] NEG_PI_FX  = -34'sd1686629713;

  localparam logic [15:0] CORDIC_GAIN = 16'h26DD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

endpackage

// File: rtl/cordic_phase_wrap.sv
// cordic_phase_wrap: combinational phase + delta, wrapped back into [-pi, pi).
// Used for the accumulator advance and for the optional quadrant fold.
module cordic_phase_wrap
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH = 32
) (
  input  logic [ANGLE_WIDTH-1:0] phase,
  input  logic [ANGLE_WIDTH-1:0] delta,
  output logic [ANGLE_WIDTH-1:0] wrapped
);

  localparam int EW = ANGLE_WIDTH + 2;

  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] fixed;
  logic                 unused_hi;

  always_comb begin
    sum = $signed({{2{phase[ANGLE_WIDTH-1]}}, phase}) +
          $signed({{2{delta[ANGLE_WIDTH-1]}}, delta});
    if (sum >= PI_FX)
      fixed = sum - TWO_PI_FX;
    else if (sum < NEG_PI_FX)
      fixed = sum + TWO_PI_FX;
    else
      fixed = sum;
  end

  // After the wrap the value always fits the narrower angle width.
  assign wrapped   = fixed[ANGLE_WIDTH-1:0];
  assign unused_hi = ^fixed[EW-1:ANGLE_WIDTH];

endmodule

// File: rtl/cordic_nco_ctrl.sv
// cordic_nco_ctrl: phase accumulator and job sequencer turning the CORDIC into a streaming NCO.
// Optional CORDIC_QUAD_FOLD_EN: fold job angles into [-pi/2, pi/2] and negate the results back.
//
// state | meaning
// IDLE  | no job in flight; starts one when enable is high
// ISSUE | one-cycle cordic_start for the latched angle
// WAIT  | waits for a rising cordic_done, aborts after TIMEOUT_CYCLES
// HOLD  | sample presented on out_*, held until out_ready
module cordic_nco_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int ANGLE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ANGLE_WIDTH-1:0] phase_step,
  input  logic                   phase_load,
  input  logic [ANGLE_WIDTH-1:0] phase_init,
  output logic                   cordic_start,
  output logic [ANGLE_WIDTH-1:0] cordic_angle,
  output logic [WIDTH-1:0]       cordic_x_start,
  output logic [WIDTH-1:0]       cordic_y_start,
  input  logic                   cordic_done,
  input  logic [WIDTH-1:0]       cordic_cos,
  input  logic [WIDTH-1:0]       cordic_sin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_cos,
  output logic [WIDTH-1:0]       out_sin,
  output logic [ANGLE_WIDTH-1:0] out_phase,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]             state;
  logic [ANGLE_WIDTH-1:0] acc;
  logic [ANGLE_WIDTH-1:0] adv_phase;
  logic [ANGLE_WIDTH-1:0] load_val;
  logic [ANGLE_WIDTH-1:0] job_angle;
  logic [ANGLE_WIDTH-1:0] out_phase_next;
  logic [TW-1:0]          timer;
  logic                   done_q;
  logic                   done_edge;
  logic                   start_job;
  logic [WIDTH-1:0]       cap_cos;
  logic [WIDTH-1:0]       cap_sin;

  assign cordic_x_start = CORDIC_GAIN;
  assign cordic_y_start = '0;
  assign cordic_start   = (state == S_ISSUE);
  assign busy           = (state != S_IDLE);

  // Only a fresh rising edge completes a job; a level left over from the previous job is ignored.
  assign done_edge = cordic_done & ~done_q;
  assign start_job = enable & ((state == S_IDLE) | ((state == S_HOLD) & out_ready));
  assign load_val  = (phase_init == PI_FX[ANGLE_WIDTH-1:0]) ? NEG_PI_FX[ANGLE_WIDTH-1:0]
                                                            : phase_init;

  cordic_phase_wrap #(.ANGLE_WIDTH(ANGLE_WIDTH)) u_advance (
    .phase   (acc),
    .delta   (phase_step),
    .wrapped (adv_phase)
  );

`ifdef CORDIC_QUAD_FOLD_EN
  logic signed [ANGLE_WIDTH+1:0] acc_ext;
  logic                          fold_hi;
  logic                          fold_lo;
  logic                          fold_q;
  logic [ANGLE_WIDTH-1:0]        fold_delta;
  logic [ANGLE_WIDTH-1:0]        folded;

  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    if (v == {1'b1, {(WIDTH-1){1'b0}}})
      return {1'b0, {(WIDTH-1){1'b1}}};
    return -v;
  endfunction

  assign acc_ext    = $signed({{2{acc[ANGLE_WIDTH-1]}}, acc});
  assign fold_hi    = (acc_ext > HALF_PI_FX);
  assign fold_lo    = (acc_ext < -HALF_PI_FX);
  assign fold_delta = fold_hi ? NEG_PI_FX[ANGLE_WIDTH-1:0] : PI_FX[ANGLE_WIDTH-1:0];

  cordic_phase_wrap #(.ANGLE_WIDTH(ANGLE_WIDTH)) u_fold (
    .phase   (acc),
    .delta   (fold_delta),
    .wrapped (folded)
  );

  assign job_angle = (fold_hi | fold_lo) ? folded : acc;
  assign cap_cos   = fold_q ? sat_neg(cordic_cos) : cordic_cos;
  assign cap_sin   = fold_q ? sat_neg(cordic_sin) : cordic_sin;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      fold_q <= 1'b0;
    else if (start_job)
      fold_q <= fold_hi | fold_lo;
  end
`else
  assign job_angle = acc;
  assign cap_cos   = cordic_cos;
  assign cap_sin   = cordic_sin;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cordic_angle   <= '0;
      out_phase_next <= '0;
    end else if (start_job) begin
      cordic_angle   <= job_angle;
      out_phase_next <= acc;
    end
  end

  // A load always wins over the advance; the job in flight keeps its latched angle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      acc <= '0;
    else if (phase_load)
      acc <= load_val;
    else if ((state == S_WAIT) && done_edge)
      acc <= adv_phase;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      done_q      <= 1'b0;
      timer       <= '0;
      out_valid   <= 1'b0;
      out_cos     <= '0;
      out_sin     <= '0;
      out_phase   <= '0;
      timeout_err <= 1'b0;
    end else begin
      done_q <= cordic_done;
      case (state)
        S_IDLE: begin
          if (start_job)
            state <= S_ISSUE;
        end
        S_ISSUE: begin
          timer <= TW'(TIMEOUT_CYCLES - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_edge) begin
            out_cos   <= cap_cos;
            out_sin   <= cap_sin;
            out_phase <= out_phase_next;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (timer == '0) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= start_job ? S_ISSUE : S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_ctrl.sv
// tb_cordic_nco_ctrl: directed bench with an ideal CORDIC stand-in and an arithmetic phase model.
// Build with or without CORDIC_QUAD_FOLD_EN; expectations follow the same macro.
module tb_cordic_nco_ctrl;

  localparam int W  = 16;
  localparam int AW = 32;
  localparam longint PI     = 64'sd1686629713;
  localparam longint HALF   = 64'sd843314857;
  localparam longint TWO_PI = 64'sd3373259426;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] phase_step = '0;
  logic          phase_load = 1'b0;
  logic [AW-1:0] phase_init = '0;
  logic          cordic_done = 1'b0;
  logic [W-1:0]  cordic_cos = '0;
  logic [W-1:0]  cordic_sin = '0;
  logic          out_ready = 1'b0;
  logic          cordic_start;
  logic [AW-1:0] cordic_angle;
  logic [W-1:0]  cordic_x_start;
  logic [W-1:0]  cordic_y_start;
  logic          out_valid;
  logic [W-1:0]  out_cos;
  logic [W-1:0]  out_sin;
  logic [AW-1:0] out_phase;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cordic_nco_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable),
    .phase_step(phase_step), .phase_load(phase_load), .phase_init(phase_init),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_x_start(cordic_x_start), .cordic_y_start(cordic_y_start),
    .cordic_done(cordic_done), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
    .out_phase(out_phase), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  function automatic longint sx(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrapf(input longint a, input longint d);
    longint t;
    t = a + d;
    if (t >= PI) t = t - TWO_PI;
    else if (t < -PI) t = t + TWO_PI;
    return t;
  endfunction

  function automatic bit foldedf(input longint a);
`ifdef CORDIC_QUAD_FOLD_EN
    return (a > HALF) || (a < -HALF);
`else
    return (a != a);
`endif
  endfunction

  function automatic longint foldf(input longint a);
    if (!foldedf(a)) return a;
    return (a > 0) ? a - PI : a + PI;
  endfunction

  function automatic int rnd(input real r);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  function automatic int rcos(input longint ph);
    return rnd(16384.0 * $cos(real'(ph) / 536870912.0));
  endfunction

  function automatic int rsin(input longint ph);
    return rnd(16384.0 * $sin(real'(ph) / 536870912.0));
  endfunction

  // Ideal CORDIC stand-in, driven on the falling edge.
  int     stub_lat = 2;
  bit     stub_level = 0;
  bit     stub_never = 0;
  bit     stub_sat = 0;
  bit     sjob = 0;
  int     scnt = 0;
  longint sang = 0;

  always @(negedge clock) begin
    if (reset || (sjob && !busy)) begin
      sjob = 0;
      if (reset) cordic_done = 1'b0;
    end else if (cordic_start) begin
      sjob = 1;
      scnt = stub_lat;
      sang = sx(cordic_angle);
      if (!stub_level) cordic_done = 1'b0;
    end else if (sjob) begin
      scnt--;
      if (stub_level && scnt == 2) cordic_done = 1'b0;
      if (scnt <= 0 && !stub_never) begin
        sjob = 0;
        cordic_done = 1'b1;
        cordic_cos = stub_sat ? 16'h8000 : W'(rcos(sang));
        cordic_sin = stub_sat ? 16'h8000 : W'(rsin(sang));
      end else if (!stub_level) begin
        cordic_done = 1'b0;
      end
    end else if (!stub_level) begin
      cordic_done = 1'b0;
    end
  end

  // Inputs as seen by the DUT on each rising edge.
  logic          ld_e = 1'b0;
  logic          rdy_e = 1'b0;
  logic [AW-1:0] init_e = '0;
  logic [AW-1:0] step_e = '0;

  always @(posedge clock) begin
    ld_e   = phase_load;
    rdy_e  = out_ready;
    init_e = phase_init;
    step_e = phase_step;
  end

  bit     chk_en = 0;
  longint m_acc = 0;
  longint q_ph[$];
  bit     q_sat[$];
  longint got_ph[$];
  logic          prev_valid = 1'b0;
  logic          prev_terr = 1'b0;
  logic [W-1:0]  pc = '0;
  logic [W-1:0]  ps = '0;
  logic [AW-1:0] pp = '0;

  always @(negedge clock) begin
    longint ph;
    bit     sat;
    bit     comp;
    if (chk_en) begin
      comp = out_valid && !prev_valid;
      if (cordic_start) begin
        chk("start_while_valid", out_valid, 0);
        chk("cordic_angle", sx(cordic_angle), foldf(m_acc));
        q_ph.push_back(m_acc);
        q_sat.push_back(stub_sat);
      end
      if (prev_valid && !rdy_e) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_cos", out_cos, pc);
        chk("hold_sin", out_sin, ps);
        chk("hold_phase", out_phase, pp);
      end
      if (timeout_err && !prev_terr) begin
        chk("timeout_had_job", q_ph.size(), 1);
        chk("timeout_no_valid", out_valid, 0);
        if (q_ph.size() > 0) begin
          ph  = q_ph.pop_front();
          sat = q_sat.pop_front();
        end
      end
      if (comp) begin
        if (q_ph.size() == 0) begin
          chk("sample_without_start", 1, 0);
        end else begin
          ph  = q_ph.pop_front();
          sat = q_sat.pop_front();
          chk("sample_phase", sx(out_phase), ph);
          if (sat) begin
            chk("sample_cos_sat", $signed(out_cos), foldedf(ph) ? 32767 : -32768);
            chk("sample_sin_sat", $signed(out_sin), foldedf(ph) ? 32767 : -32768);
          end else begin
            chk_near("sample_cos", longint'($signed(out_cos)), rcos(ph), 2);
            chk_near("sample_sin", longint'($signed(out_sin)), rsin(ph), 2);
          end
        end
        got_ph.push_back(sx(out_phase));
      end
      if (ld_e)
        m_acc = (sx(init_e) == PI) ? -PI : sx(init_e);
      else if (comp)
        m_acc = wrapf(m_acc, sx(step_e));
    end
    prev_valid = out_valid;
    prev_terr  = timeout_err;
    pc = out_cos;
    ps = out_sin;
    pp = out_phase;
  end

  task automatic step_cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < 400 && got_ph.size() < n; i++) step_cyc();
    chk("wait_samples", got_ph.size() >= n, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy || out_valid); i++) step_cyc();
    chk("wait_idle", busy || out_valid, 0);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 100 && !cordic_start; i++) step_cyc();
    chk("wait_start", cordic_start, 1);
  endtask

  task automatic load_phase(input logic [AW-1:0] v);
    phase_init = v;
    phase_load = 1'b1;
    step_cyc();
    phase_load = 1'b0;
  endtask

  initial begin
    int     base;
    int     n;
    longint t4_acc;

    repeat (3) step_cyc();
    chk("rst_start", cordic_start, 0);
    chk("rst_angle", cordic_angle, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cos", out_cos, 0);
    chk("rst_sin", out_sin, 0);
    chk("rst_phase", out_phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_xstart", cordic_x_start, 16'h26DD);
    chk("rst_ystart", cordic_y_start, 0);
    reset  = 1'b0;
    chk_en = 1;

    // quarter-turn steps from reset
    base = got_ph.size();
    phase_step = 32'sd843314856;
    out_ready  = 1'b1;
    enable     = 1'b1;
    wait_n(base + 4);
    enable = 1'b0;
    wait_idle();
    chk("t1_ph0", got_ph[base],   0);
    chk("t1_ph1", got_ph[base+1], 843314856);
    chk("t1_ph2", got_ph[base+2], 1686629712);
    chk("t1_ph3", got_ph[base+3], -843314858);

    // negative step crossing -pi
    load_phase(-32'sd1500000000);
    base = got_ph.size();
    phase_step = -32'sd1000000000;
    enable = 1'b1;
    wait_n(base + 3);
    enable = 1'b0;
    wait_idle();
    chk("t1b_ph0", got_ph[base],   -1500000000);
    chk("t1b_ph1", got_ph[base+1], 873259426);
    chk("t1b_ph2", got_ph[base+2], -126740574);

    // done held as a level across jobs
    stub_level = 1;
    stub_lat   = 4;
    phase_step = 32'sd300000000;
    base = got_ph.size();
    enable = 1'b1;
    wait_n(base + 3);
    enable = 1'b0;
    wait_idle();
    chk("t2_outstanding", q_ph.size(), 0);
    stub_level = 0;
    stub_lat   = 2;

    // back-pressure in HOLD
    out_ready = 1'b0;
    enable    = 1'b1;
    for (int i = 0; i < 100 && !out_valid; i++) step_cyc();
    chk("t3_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step_cyc();
      chk("t3_no_start", cordic_start, 0);
    end
    out_ready = 1'b1;
    step_cyc();
    chk("t3_restart", cordic_start, 1);
    enable = 1'b0;
    wait_idle();

    // CORDIC never answers
    stub_never = 1;
    enable = 1'b1;
    wait_start();
    enable = 1'b0;
    t4_acc = m_acc;
    n = 0;
    while (!timeout_err && n < 100) begin
      step_cyc();
      n++;
    end
    chk("t4_timeout_cycles", n, 65);
    chk("t4_busy", busy, 0);
    chk("t4_valid", out_valid, 0);
    stub_never = 0;
    step_cyc();
    base = got_ph.size();
    enable = 1'b1;
    wait_n(base + 1);
    enable = 1'b0;
    wait_idle();
    chk("t4_acc_kept", got_ph[base], t4_acc);
    chk("t4_terr_sticky", timeout_err, 1);

    // load of +pi on the same edge as an advance
    load_phase(32'sd500000000);
    phase_step = 32'sd100000000;
    base = got_ph.size();
    enable = 1'b1;
    wait_start();
    step_cyc();
    step_cyc();
    phase_init = 32'sd1686629713;
    phase_load = 1'b1;
    step_cyc();
    phase_load = 1'b0;
    chk("t5_valid", out_valid, 1);
    chk("t5_old_phase", sx(out_phase), 500000000);
    wait_n(base + 2);
    enable = 1'b0;
    wait_idle();
    chk("t5_loaded_phase", got_ph[base+1], -1686629713);

    // angle just below +pi: fold, saturation, then reset mid-job
    phase_step = '0;
    load_phase(32'sd1686629712);
    stub_sat = 1;
    base = got_ph.size();
    enable = 1'b1;
    wait_start();
`ifdef CORDIC_QUAD_FOLD_EN
    chk("t6_angle", sx(cordic_angle), -1);
`else
    chk("t6_angle", sx(cordic_angle), 1686629712);
`endif
    enable = 1'b0;
    wait_n(base + 1);
    wait_idle();
    chk("t6_sat_phase", got_ph[base], 1686629712);
`ifdef CORDIC_QUAD_FOLD_EN
    chk("t6_sat_cos", $signed(out_cos), 32767);
`else
    chk("t6_sat_cos", $signed(out_cos), -32768);
`endif
    stub_sat = 0;
    enable = 1'b1;
    wait_n(base + 2);
    enable = 1'b0;
    wait_idle();
    chk_near("t6_cos", longint'($signed(out_cos)), -16384, 2);
    chk("t6_phase", sx(out_phase), 1686629712);

    stub_lat = 8;
    enable = 1'b1;
    wait_start();
    step_cyc();
    step_cyc();
    chk("t6_busy_wait", busy, 1);
    chk_en = 0;
    reset  = 1'b1;
    #1;
    chk("t6r_start", cordic_start, 0);
    chk("t6r_angle", cordic_angle, 0);
    chk("t6r_valid", out_valid, 0);
    chk("t6r_cos", out_cos, 0);
    chk("t6r_sin", out_sin, 0);
    chk("t6r_phase", out_phase, 0);
    chk("t6r_busy", busy, 0);
    chk("t6r_terr", timeout_err, 0);
    chk("t6r_xstart", cordic_x_start, 16'h26DD);
    enable = 1'b0;
    step_cyc();
    step_cyc();
    m_acc = 0;
    q_ph.delete();
    q_sat.delete();
    stub_lat = 2;
    reset  = 1'b0;
    chk_en = 1;
    base = got_ph.size();
    repeat (12) step_cyc();
    chk("t6r_no_output", got_ph.size(), base);
    enable = 1'b1;
    wait_n(base + 1);
    enable = 1'b0;
    wait_idle();
    chk("t6r_phase_zero", got_ph[base], 0);
    chk("final_outstanding", q_ph.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
